// File: rtl/keypad_encoder_if.sv
// CPU-side port bundle of the keypad encoder: matrix lines plus the
// read-acknowledge handshake and the registered key/valid/overrun status.
interface keypad_encoder_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       rd;
    logic [3:0] key;
    logic       valid;
    logic       overrun;

    modport slave (
        input  rows,
        input  rd,
        output cols,
        output key,
        output valid,
        output overrun
    );

    modport master (
        output rows,
        output rd,
        input  cols,
        input  key,
        input  valid,
        input  overrun
    );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner: column scan, frame classification,
// frame-level debounce and a single report per press held for the CPU.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no key accepted; waiting for a debounced SINGLE frame
// ST_PRESSED | a key was reported; waiting for a debounced NONE frame
module keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input logic             clk,
    input logic             reset,
    keypad_encoder_if.slave bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_kind_t;

    // code is forced to zero for NONE/MULTI so whole-struct compare is frame equality
    typedef struct packed {
        frame_kind_t kind;
        logic [3:0]  code;
    } frame_t;

    state_t        state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [1:0]    col_q,     col_d;
    logic [3:0]    cols_q,    cols_d;
    logic [11:0]   samp_q,    samp_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    frame_t        prev_q,    prev_d;
    logic [3:0]    key_q,     key_d;
    logic          valid_q,   valid_d;
    logic          overrun_q, overrun_d;

    logic          sample;
    logic          frame_edge;
    logic [15:0]   hits;
    logic [4:0]    n_hits;
    logic [3:0]    hit_code;
    frame_t        frame;
    logic          stable;
    logic          report;
    logic          release_key;

    // Key matrix for the frame: columns 0-2 from stored samples, column 3 live.
    always_comb begin
        hits = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (c == 3) hits[4*r + c] = ~bus.rows[r];
                else        hits[4*r + c] = ~samp_q[4*c + r];
            end
        end
        n_hits   = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            n_hits = n_hits + {4'd0, hits[i]};
            if (hits[i]) hit_code = 4'(i);
        end
        frame.code = '0;
        if (n_hits == 5'd0) begin
            frame.kind = FR_NONE;
        end else if (n_hits == 5'd1) begin
            frame.kind = FR_SINGLE;
            frame.code = hit_code;
        end else begin
            frame.kind = FR_MULTI;
        end
    end

    always_comb begin
        presc_d   = presc_q;
        col_d     = col_q;
        cols_d    = cols_q;
        samp_d    = samp_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        state_d   = state_q;
        key_d     = key_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        sample      = (presc_q == PW'(SCAN_DIV - 1));
        frame_edge  = sample && (col_q == 2'd3);
        stable      = 1'b0;
        report      = 1'b0;
        release_key = 1'b0;

        if (sample) begin
            presc_d = '0;
            col_d   = col_q + 2'd1;
            cols_d  = ~(4'b0001 << col_d);
            if (col_q != 2'd3) samp_d[{col_q, 2'b00} +: 4] = bus.rows;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (frame_edge) begin
            if (frame == prev_q)
                cnt_d = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + CW'(1);
            else
                cnt_d = CW'(1);
            prev_d      = frame;
            stable      = (cnt_d == CW'(DEBOUNCE));
            report      = stable && (state_q == ST_IDLE)    && (frame.kind == FR_SINGLE);
            release_key = stable && (state_q == ST_PRESSED) && (frame.kind == FR_NONE);
        end

        if (report)           state_d = ST_PRESSED;
        else if (release_key) state_d = ST_IDLE;

        // A report on the same edge as rd takes precedence over the clear.
        if (report) begin
            key_d     = frame.code;
            valid_d   = 1'b1;
            overrun_d = bus.rd ? 1'b0 : (overrun_q | valid_q);
        end else if (bus.rd) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            col_q     <= '0;
            cols_q    <= 4'b1110;
            samp_q    <= '1;
            cnt_q     <= '0;
            prev_q    <= '{kind: FR_NONE, code: 4'd0};
            key_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            col_q     <= col_d;
            cols_q    <= cols_d;
            samp_q    <= samp_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.cols    = cols_q;
    assign bus.key     = key_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a physical keypad model drives rows from cols,
// and a frame-level reference model predicts key/valid/overrun.
module tb_keypad_encoder;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        reset;
    logic        rd;
    logic [15:0] key_mask;
    logic [3:0]  rows_drv;

    int n_checks;
    int n_pass;
    int n_fail;

    // reference model: frame class is -1 NONE, -2 MULTI, else the key code
    int   m_prev;
    int   m_cnt;
    bit   m_pressed;
    bit   m_valid;
    int   m_key;
    bit   m_over;

    keypad_encoder_if kif ();

    keypad_encoder #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a pressed key (r,c) shorts row r to column c
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows_drv[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (key_mask[4*r + c] && !kif.cols[c]) rows_drv[r] = 1'b0;
        end
    end

    assign kif.rows = rows_drv;
    assign kif.rd   = rd;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int classify(input logic [15:0] m);
        int n, code;
        n = 0;
        code = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin n++; code = i; end
        if (n == 0) return -1;
        if (n == 1) return code;
        return -2;
    endfunction

    task automatic model_reset();
        m_prev = -1; m_cnt = 0; m_pressed = 0;
        m_valid = 0; m_key = 0; m_over = 0;
    endtask

    task automatic model_frame(input logic [15:0] m, input bit rd_edge);
        int f;
        bit settled;
        f = classify(m);
        if (f == m_prev) m_cnt = (m_cnt < DEBOUNCE) ? m_cnt + 1 : DEBOUNCE;
        else             m_cnt = 1;
        m_prev  = f;
        settled = (m_cnt == DEBOUNCE);
        if (!m_pressed && f >= 0 && settled) begin
            m_over    = rd_edge ? 1'b0 : (m_over | m_valid);
            m_valid   = 1;
            m_key     = f;
            m_pressed = 1;
        end else begin
            if (rd_edge) begin m_valid = 0; m_over = 0; end
            if (m_pressed && f == -1 && settled) m_pressed = 0;
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, "_valid"},   {15'd0, kif.valid},   {15'd0, m_valid});
        check({where, "_overrun"}, {15'd0, kif.overrun}, {15'd0, m_over});
        check({where, "_key"},     {12'd0, kif.key},     16'(m_key));
    endtask

    // One frame with mask held throughout; rd_at (1..FRAME) pulses rd on that edge.
    task automatic run_frame(input logic [15:0] m, input int rd_at);
        logic [3:0] exp_cols;
        key_mask = m;
        for (int i = 1; i <= FRAME; i++) begin
            rd = (i == rd_at);
            @(posedge clk);
            @(negedge clk);
            rd = 1'b0;
            exp_cols = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            check("cols", {12'd0, kif.cols}, {12'd0, exp_cols});
            if (i < FRAME) begin
                if (i == rd_at) begin m_valid = 0; m_over = 0; end
                check("mid_valid",   {15'd0, kif.valid},   {15'd0, m_valid});
                check("mid_overrun", {15'd0, kif.overrun}, {15'd0, m_over});
            end
        end
        model_frame(m, rd_at == FRAME);
        check_outputs("frame");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_cols",    {12'd0, kif.cols},    16'h000e);
        check("rst_valid",   {15'd0, kif.valid},   16'h0000);
        check("rst_key",     {12'd0, kif.key},     16'h0000);
        check("rst_overrun", {15'd0, kif.overrun}, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    logic [15:0] cur;
    logic [15:0] rmask;
    int          sel;
    int          rda;
    int          ka;
    int          kb;

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        reset = 1'b1; rd = 1'b0; key_mask = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        key_mask = 16'h0200;
        do_reset();

        // key(2,1) held from reset: report at the end of frame 2, then no more
        for (int n = 0; n < 15; n++) run_frame(16'h0200, 0);
        run_frame(16'h0200, 5);
        run_frame(16'h0000, 0);
        run_frame(16'h0000, 0);
        run_frame(16'h0008, 0);
        run_frame(16'h0008, 0);

        // bouncing key(1,1), then two keys held together
        for (int n = 0; n < 10; n++) run_frame((n % 2 == 0) ? 16'h0020 : 16'h0000, (n == 0) ? 3 : 0);
        for (int n = 0; n < 4; n++)  run_frame(16'h8001, 0);

        // overrun: unread key 5 overwritten by key 6, then read
        run_frame(16'h0000, 0); run_frame(16'h0000, 0);
        run_frame(16'h0020, 0); run_frame(16'h0020, 0);
        run_frame(16'h0000, 0); run_frame(16'h0000, 0);
        run_frame(16'h0040, 0); run_frame(16'h0040, 0);
        run_frame(16'h0040, 4);
        // same again with rd on the exact report edge
        run_frame(16'h0000, 0); run_frame(16'h0000, 0);
        run_frame(16'h0020, 0); run_frame(16'h0020, 0);
        run_frame(16'h0000, 0); run_frame(16'h0000, 0);
        run_frame(16'h0040, 0); run_frame(16'h0040, FRAME);
        run_frame(16'h0040, 2);

        // reset in the middle of the second debounce frame
        run_frame(16'h0000, 0); run_frame(16'h0000, 0);
        run_frame(16'h0400, 0);
        repeat (8) @(negedge clk);
        do_reset();
        run_frame(16'h0400, 0);
        run_frame(16'h0400, 0);

        // randomized frames against the reference model
        cur = 16'h0400;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                rmask = cur;
            end else if (sel < 6) begin
                rmask = 16'h0000;
            end else if (sel < 9) begin
                rmask = 16'h0001 << $urandom_range(0, 15);
            end else begin
                ka = $urandom_range(0, 15);
                kb = (ka + 1 + $urandom_range(0, 14)) % 16;
                rmask = (16'h0001 << ka) | (16'h0001 << kb) | 16'($urandom);
            end
            rda = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FRAME) : 0;
            run_frame(rmask, rda);
            cur = rmask;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Scans a 4x4 active-low matrix keypad and turns one debounced keypress into a 4-bit binary code.
- Acts as an input-port peripheral for the CPU I/O mux; it is the input-side counterpart of the binary-to-7-segment output path.
- Holds the code with a valid flag until the CPU acknowledges it with a read strobe.

Parameters:
- SCAN_DIV, 1000, clk cycles spent driving each column (at least 2).
- DEBOUNCE, 4, consecutive identical full-scan frames required before a press or release is accepted (at least 1).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-high
- rows  input  4  keypad row lines, active-low (pulled up externally, synchronised externally)
- cols  output  4  keypad column drive, active-low, exactly one bit low
- rd  input  1  single-cycle CPU read acknowledge
- key  output  4  last accepted key code
- valid  output  1  key holds an unread code
- overrun  output  1  an unread code was overwritten

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - cols=4'b1110, key=0, valid=0, overrun=0.
  - Prescaler=0, column index=0, stable count=0, previous frame=NONE, state=IDLE.
  - Reset asserted mid-scan or mid-debounce discards all partial results.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On the edge where prescaler=SCAN_DIV-1, rows is sampled for the current column c, the prescaler wraps to 0 and c advances, 3 wrapping to 0.
  - cols = ~(1<<c).
- Key code: row r reading 0 while column c is driven means key(r,c); code = 4*r + c.
- Frame: the result of columns 0..3. It is evaluated on the edge that samples column 3, using the stored samples of columns 0-2 plus the current rows. The frame is one of:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one key asserted.
  - MULTI: two or more keys asserted.
- Debounce, on each frame edge:
  - If the frame equals the previous frame, stable count increments, saturating at DEBOUNCE.
  - Otherwise stable count=1.
  - Previous frame is then set to the current frame.
- State machine, evaluated on frame edges with the updated stable count:
  - IDLE -> PRESSED when the frame is SINGLE(code) and count=DEBOUNCE. On that edge key<=code and valid<=1; if valid was already 1 and rd is not asserted on that edge, overrun<=1.
  - PRESSED -> IDLE when the frame is NONE and count=DEBOUNCE.
  - MULTI frames, or a different SINGLE frame seen while PRESSED, cause no report and no release.
  - A key held indefinitely produces exactly one report.
- Read:
  - rd=1 on an edge clears valid and overrun.
  - If a report occurs on the same edge, the report wins: valid=1, key=new code, overrun=0.
  - rd while valid=0 has no effect.
- Latency: a clean press stable from the first cycle of a frame reports on the edge ending frame DEBOUNCE, i.e. 4*SCAN_DIV*DEBOUNCE cycles after that frame starts.
- Outputs are registered only; there is no combinational path from rows or rd to the outputs.

Test Plan:
- Hold reset high, then release -> cols=1110, valid=0, key=0, overrun=0; cols then rotates 1101, 1011, 0111, 1110 every SCAN_DIV cycles.
- SCAN_DIV=4, DEBOUNCE=2; key(2,1) held from reset -> valid rises on edge 32 with key=4'h9; held for 200 more cycles -> no further report and valid stays 1.
- rd pulse -> valid=0 after that edge. Release for 2 frames, then press key(0,3) -> key=4'h3 and valid=1 after 2 frames.
- Key(1,1) toggled every frame (bouncing) for 10 frames -> valid never asserts. Keys (0,0) and (3,3) held together -> valid never asserts.
- Overrun sequence:
  - Press key 5 and release without rd, then press key 6 -> key=4'h6, valid=1, overrun=1.
  - rd -> valid=0, overrun=0.
  - Repeat with rd on the exact report edge -> valid=1, overrun=0.
- Assert reset two frames into a debounce, then release with the key still held -> the report occurs only after a full DEBOUNCE frames counted from the reset release.
